sprite_cmd_scheduler: RTL and testbench
=======================================

Name: sprite_cmd_scheduler

Overview:
Sequences CPU sprite commands onto the shared 32-bit command bus that feeds every sprite display module (Mario, enemies, blocks, and so on). It buffers Avalon writes in a FIFO and drains them at one word per cycle. It holds each buffer-swap command (command field 4'b1111) until the next vertical-blank entry, so the front sprite buffer never changes mid-frame. It sits between the Avalon slave and all display modules, which it drives with the same VGA hcount and vcount.

Parameters:
FIFO_DEPTH, 16, command FIFO entries; power of 2, at most 128.
VBLANK_LINE, 480, first vcount value of vertical blank.
NOP_WORD, 32'h0000_0000, idle bus word; command field 4'b0000, ignored by all display modules.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
chipselect  in  1  Avalon slave select.
write  in  1  Avalon write strobe.
address  in  1  0 = command push, 1 = control/status.
writedata  in  32  push word (address 0) or control bits (address 1).
readdata  out  32  status; combinational, zero read latency.
hcount  in  10  VGA horizontal count.
vcount  in  10  VGA vertical count.
cmd_out  out  32  registered command word broadcast to the display modules.
front_buffer  out  1  buffer currently displayed (last issued swap toggle bit).
frame_done  out  1  one-cycle pulse when a swap is issued.

Behaviour:
- Reset: asynchronous, active-high. Clears the following immediately:
  - FIFO emptied; state DRAIN.
  - cmd_out = NOP_WORD; front_buffer = 0; frame_done = 0.
  - overflow = 0; vblank_q = 0.
- Command word fields: [31:26] component, [25:21] sub, [20:17] command, [16:14] type, [13] buffer toggle, [12:0] data. The scheduler inspects only [20:17] and [13].
- Push: chipselect & write & address==0.
  - Not full: word enqueued.
  - Full with no pop this cycle: word dropped; overflow sets and is sticky.
  - Full with a pop this cycle: push accepted; count unchanged.
- Control write (address 1):
  - bit0 = 1 clears overflow.
  - bit1 = 1 flushes: FIFO emptied, pending swap discarded, state DRAIN, cmd_out = NOP_WORD on the next cycle.
  - Flush takes priority over a same-cycle pop.
- readdata when address==1: [15:8] fill count, [2] swap_pending (state SWAP_WAIT), [1] front_buffer, [0] overflow; all other bits 0. When address==0, readdata = 0.
- vblank = (vcount >= VBLANK_LINE). vblank_q is registered every cycle. vb_rise = vblank & ~vblank_q.
- State DRAIN:
  - FIFO empty: cmd_out <= NOP_WORD.
  - Head command != 4'b1111: cmd_out <= head; pop. Each word is driven for exactly one cycle.
  - Head command == 4'b1111: pop into swap_reg; cmd_out <= NOP_WORD; go to SWAP_WAIT.
- State SWAP_WAIT:
  - cmd_out <= NOP_WORD. No pops; later commands wait because they target the new back buffer.
  - Pushes continue to be accepted.
  - On vb_rise: cmd_out <= swap_reg; front_buffer <= swap_reg[13]; frame_done <= 1 for one cycle; go to DRAIN.
  - A swap reaching the head while vblank is already high waits for the next rising edge, i.e. one full frame.
- Latency: with the FIFO empty and state DRAIN, a word accepted at edge N appears on cmd_out after edge N+1, for one cycle.
- Throughput: one word per cycle.
- Back-to-back swaps: each swap waits for its own vb_rise, so at most one swap is issued per frame.
- Reset mid-SWAP_WAIT: the pending swap is lost; front_buffer returns to 0.

Test Plan:
1. Reset, then push 32'h0402_4064 and 32'h0402_8000 on consecutive cycles -> cmd_out shows each word for exactly one cycle, on the cycles after their push edges, then NOP_WORD; fill count returns to 0.
2. Push sprite word, swap 32'h001E_2000, sprite word B, with vcount = 100 -> the first word issues; swap_pending = 1; B is held; at vcount 479->480 cmd_out = 32'h001E_2000 for one cycle, frame_done pulses, front_buffer = 1; B issues on the next cycle.
3. With vcount = 490 (already in vblank), push a swap -> no issue until the following 479->480 transition; readdata[2] = 1 throughout.
4. Hold state SWAP_WAIT and push 17 words (depth 16) -> fill count = 16, overflow = 1; a control write with bit0 = 1 -> overflow = 0.
5. In SWAP_WAIT with 5 queued words, control write bit1 = 1 -> fill count = 0, swap_pending = 0, cmd_out = NOP_WORD; the next vb_rise produces no frame_done.
6. Assert reset asynchronously mid-drain while cmd_out is non-NOP -> cmd_out = 0, front_buffer = 0, and readdata = 0 at address 1, with no clock edge.

Source files
------------

// File: rtl/sprite_cmd_if.sv
// Avalon-MM slave bus between the CPU bridge and the sprite command scheduler.
// A push is accepted on any cycle with chipselect & write & ~address; there is no
// waitrequest, so a push into a full FIFO with no pop that cycle is dropped and flagged.
interface sprite_cmd_if;
  logic        chipselect;
  logic        write;
  logic        address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, write, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, address, writedata,
    output readdata
  );
endinterface

// File: rtl/sprite_cmd_scheduler.sv
// Buffers CPU sprite commands and drains them one per cycle onto the display command
// bus, holding each buffer-swap command until the next vertical-blank entry.
module sprite_cmd_scheduler #(
  parameter int          FIFO_DEPTH  = 16,
  parameter int          VBLANK_LINE = 480,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  sprite_cmd_if.slave       bus,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic [31:0]       cmd_out,
  output logic              front_buffer,
  output logic              frame_done,
  output logic [0:0]        fsm_state
);
  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam int             CW       = AW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [9:0]     VB_LINE  = 10'(VBLANK_LINE);
  localparam logic [3:0]     CMD_SWAP = 4'b1111;

  localparam logic [0:0] S_DRAIN     = 1'b0;
  localparam logic [0:0] S_SWAP_WAIT = 1'b1;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [0:0]    state;
  logic [31:0]   swap_reg;
  logic          overflow;
  logic          vblank_q;

  logic        push_req, ctrl_wr, flush, clr_ovf;
  logic        empty, full, pop, push_ok;
  logic        vblank, vb_rise;
  logic [31:0] head;

  // hcount is carried for timing context only; the scheduler keys off vcount.
  logic unused_hcount;
  assign unused_hcount = ^hcount;

  assign push_req = bus.chipselect & bus.write & ~bus.address;
  assign ctrl_wr  = bus.chipselect & bus.write & bus.address;
  assign flush    = ctrl_wr & bus.writedata[1];
  assign clr_ovf  = ctrl_wr & bus.writedata[0];

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign pop     = (state == S_DRAIN) & ~empty & ~flush;
  assign push_ok = push_req & (~full | pop);

  assign vblank  = (vcount >= VB_LINE);
  assign vb_rise = vblank & ~vblank_q;

  assign fsm_state = state;

  always_comb begin
    bus.readdata = '0;
    if (bus.address) begin
      bus.readdata[15:8] = 8'(count);
      bus.readdata[2]    = (state == S_SWAP_WAIT);
      bus.readdata[1]    = front_buffer;
      bus.readdata[0]    = overflow;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      state        <= S_DRAIN;
      swap_reg     <= NOP_WORD;
      cmd_out      <= NOP_WORD;
      front_buffer <= 1'b0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      vblank_q     <= 1'b0;
    end else begin
      vblank_q   <= vblank;
      frame_done <= 1'b0;

      if (clr_ovf)
        overflow <= 1'b0;
      else if (push_req & full & ~pop)
        overflow <= 1'b1;

      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        state   <= S_DRAIN;
        cmd_out <= NOP_WORD;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        if (push_ok & ~pop)
          count <= count + CW'(1);
        else if (pop & ~push_ok)
          count <= count - CW'(1);

        case (state)
          S_DRAIN: begin
            if (empty) begin
              cmd_out <= NOP_WORD;
            end else if (head[20:17] == CMD_SWAP) begin
              swap_reg <= head;
              cmd_out  <= NOP_WORD;
              state    <= S_SWAP_WAIT;
            end else begin
              cmd_out <= head;
            end
          end
          default: begin
            // Later commands target the new back buffer, so nothing pops until the swap issues.
            if (vb_rise) begin
              cmd_out      <= swap_reg;
              front_buffer <= swap_reg[13];
              frame_done   <= 1'b1;
              state        <= S_DRAIN;
            end else begin
              cmd_out <= NOP_WORD;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// Directed bench for sprite_cmd_scheduler: stimulus pushes expected bus words into a
// queue and a negedge monitor pops and compares whenever cmd_out carries a command.
module tb_sprite_cmd_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  hcount = 10'd0;
  logic [9:0]  vcount = 10'd100;
  logic [31:0] cmd_out;
  logic        front_buffer;
  logic        frame_done;
  logic [0:0]  fsm_state;

  sprite_cmd_if bus();

  sprite_cmd_scheduler #(
    .FIFO_DEPTH (16),
    .VBLANK_LINE(480),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .hcount      (hcount),
    .vcount      (vcount),
    .cmd_out     (cmd_out),
    .front_buffer(front_buffer),
    .frame_done  (frame_done),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  int          frames = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc[$];
  logic [31:0] mon_w;
  int          mon_t;
  logic        mon_swap;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] w, input int t);
    exp_q.push_back(w);
    exp_cyc.push_back(t);
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) frames++;
      if (cmd_out !== 32'h0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_out_unexpected: got %h expected none", cmd_out);
        end else begin
          mon_w    = exp_q.pop_front();
          mon_t    = exp_cyc.pop_front();
          mon_swap = (mon_w[20:17] == 4'hF);
          check("cmd_out", cmd_out, mon_w);
          if (mon_t >= 0) check("cmd_cycle", 32'(cyc), 32'(mon_t));
          check("frame_done_with_word", {31'b0, frame_done}, {31'b0, mon_swap});
          if (mon_swap) check("front_after_swap", {31'b0, front_buffer}, {31'b0, mon_w[13]});
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_done_spurious: got 1 expected 0 with cmd_out NOP");
      end
    end
  end

  // driver tasks
  task automatic bus_write(input logic a, input logic [31:0] d, output int acc);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk);
    #1;
    acc            = cyc;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 1'b0;
  endtask

  task automatic read_status(output logic [31:0] d);
    bus.address    = 1'b1;
    bus.chipselect = 1'b1;
    #1;
    d              = bus.readdata;
    bus.address    = 1'b0;
    bus.chipselect = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vblank_edge();
    vcount = 10'd479;
    step(1);
    vcount = 10'd480;
    step(1);
  endtask

  logic [31:0] st;
  int          a;

  initial begin
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 1'b0;
    bus.writedata  = 32'h0;
    step(3);
    reset = 1'b0;

    read_status(st);
    check("reset_status", st, 32'h0);
    check("reset_cmd_out", cmd_out, 32'h0);
    check("reset_front", {31'b0, front_buffer}, 32'h0);
    check("reset_frame_done", {31'b0, frame_done}, 32'h0);

    // back-to-back pushes, one-cycle latency and one cycle on the bus each
    bus_write(1'b0, 32'h0402_4064, a); expect_word(32'h0402_4064, a + 1);
    bus_write(1'b0, 32'h0402_8000, a); expect_word(32'h0402_8000, a + 1);
    step(3);
    read_status(st);
    check("t1_fill", {24'b0, st[15:8]}, 32'h0);

    // swap held until vblank entry, later word held behind it
    bus_write(1'b0, 32'h0800_1234, a); expect_word(32'h0800_1234, a + 1);
    bus_write(1'b0, 32'h001E_2000, a); expect_word(32'h001E_2000, -1);
    bus_write(1'b0, 32'h0C00_0042, a); expect_word(32'h0C00_0042, -1);
    step(3);
    read_status(st);
    check("t2_pending", {31'b0, st[2]}, 32'h1);
    check("t2_fill", {24'b0, st[15:8]}, 32'h1);
    check("t2_fsm_state", {31'b0, fsm_state}, 32'h1);
    check("t2_front_before", {31'b0, front_buffer}, 32'h0);
    vblank_edge();
    check("t2_front_after", {31'b0, front_buffer}, 32'h1);
    step(3);
    check("t2_frames", 32'(frames), 32'd1);
    read_status(st);
    check("t2_fill_after", {24'b0, st[15:8]}, 32'h0);
    check("t2_pending_after", {31'b0, st[2]}, 32'h0);

    // swap arriving inside vblank waits a full frame
    vcount = 10'd490;
    step(2);
    bus_write(1'b0, 32'h001E_0000, a); expect_word(32'h001E_0000, -1);
    for (int i = 0; i < 4; i++) begin
      step(4);
      read_status(st);
      check("t3_pending", {31'b0, st[2]}, 32'h1);
    end
    check("t3_frames_hold", 32'(frames), 32'd1);
    vcount = 10'd100;
    step(2);
    vblank_edge();
    check("t3_front", {31'b0, front_buffer}, 32'h0);
    step(2);
    check("t3_frames", 32'(frames), 32'd2);

    // fill past depth while holding a swap, then drain with push-on-pop at full
    vcount = 10'd100;
    step(2);
    bus_write(1'b0, 32'h001E_2000, a); expect_word(32'h001E_2000, -1);
    step(2);
    for (int i = 0; i < 16; i++) begin
      bus_write(1'b0, 32'h0400_0000 | 32'(i), a);
      expect_word(32'h0400_0000 | 32'(i), -1);
    end
    bus_write(1'b0, 32'h0400_00FF, a);
    read_status(st);
    check("t4_fill_full", {24'b0, st[15:8]}, 32'd16);
    check("t4_overflow", {31'b0, st[0]}, 32'h1);
    bus_write(1'b1, 32'h0000_0001, a);
    read_status(st);
    check("t4_overflow_clr", {31'b0, st[0]}, 32'h0);
    check("t4_fill_kept", {24'b0, st[15:8]}, 32'd16);
    step(1);
    vblank_edge();
    bus_write(1'b0, 32'h0400_0100, a); expect_word(32'h0400_0100, -1);
    read_status(st);
    check("t4_fill_push_on_pop", {24'b0, st[15:8]}, 32'd16);
    check("t4_no_overflow", {31'b0, st[0]}, 32'h0);
    step(20);
    read_status(st);
    check("t4_fill_drained", {24'b0, st[15:8]}, 32'h0);
    check("t4_frames", 32'(frames), 32'd3);

    // flush discards the pending swap and queued words
    vcount = 10'd100;
    step(2);
    bus_write(1'b0, 32'h001E_0000, a);
    step(2);
    for (int i = 0; i < 5; i++) bus_write(1'b0, 32'h0500_0000 | 32'(i), a);
    read_status(st);
    check("t5_fill", {24'b0, st[15:8]}, 32'd5);
    check("t5_pending", {31'b0, st[2]}, 32'h1);
    bus_write(1'b1, 32'h0000_0002, a);
    check("t5_cmd_nop", cmd_out, 32'h0);
    read_status(st);
    check("t5_fill_flushed", {24'b0, st[15:8]}, 32'h0);
    check("t5_pending_flushed", {31'b0, st[2]}, 32'h0);
    vblank_edge();
    step(4);
    check("t5_frames", 32'(frames), 32'd3);
    check("t5_front", {31'b0, front_buffer}, 32'h1);

    // asynchronous reset mid-drain
    vcount = 10'd100;
    step(2);
    bus_write(1'b0, 32'h0600_0001, a); expect_word(32'h0600_0001, a + 1);
    bus_write(1'b0, 32'h0600_0002, a); expect_word(32'h0600_0002, a + 1);
    bus_write(1'b0, 32'h0600_0003, a);
    bus_write(1'b0, 32'h0600_0004, a);
    check("t6_cmd_before_reset", cmd_out, 32'h0600_0003);
    #1;
    reset = 1'b1;
    #1;
    check("t6_cmd_reset", cmd_out, 32'h0);
    check("t6_front_reset", {31'b0, front_buffer}, 32'h0);
    check("t6_frame_done_reset", {31'b0, frame_done}, 32'h0);
    read_status(st);
    check("t6_status_reset", st, 32'h0);
    step(2);
    reset = 1'b0;
    step(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
